shift_right_sticky_pipe: RTL and testbench

SHIFT_RIGHT_STICKY_PIPE -- requirements
Module: shift_right_sticky_pipe

---
 rtl/shift_right_sticky_pipe.sv | 89 ++++++++
 tb/tb_shift_right_sticky_pipe.sv | 137 +++++++++++++
 2 files changed

// File: rtl/shift_right_sticky_pipe.sv
// shift_right_sticky_pipe: pipelined right shifter with sticky OR/AND of shifted-out bits.
// Ports: clock/reset (async, active-high); inValid/inReady/in/shift/arith input handshake;
// outValid/outReady/out/sticky/stickyAnd result handshake.
// Macro SHIFT_RIGHT_STICKY_PIPE_ARITH_EN enables arithmetic (sign-fill) mode.
module shift_right_sticky_pipe #(
  parameter int IN_WIDTH    = 6,
  parameter int OUT_WIDTH   = 6,
  parameter int SHIFT_WIDTH = $clog2(IN_WIDTH + 1),
  parameter int STAGES      = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [IN_WIDTH-1:0]    in,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   arith,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [OUT_WIDTH-1:0]   out,
  output logic                   sticky,
  output logic                   stickyAnd
);
  localparam logic [IN_WIDTH-1:0] ONES = '1;
  // om marks positions still holding original input bits, so shifted-in fill never
  // pollutes the sticky accumulators once the shift passes the operand width.
  typedef struct packed {
    logic [IN_WIDTH-1:0]    d;
    logic [IN_WIDTH-1:0]    om;
    logic [SHIFT_WIDTH-1:0] sh;
    logic                   st;
    logic                   sa;
    logic                   f;
  } stg_t;
  // Stage s applies shift bits [s*SW/STAGES, (s+1)*SW/STAGES).
  function automatic stg_t step(input stg_t x, input int s);
    stg_t y;
    logic [IN_WIDTH-1:0] m;
    y = x;
    for (int b = s * SHIFT_WIDTH / STAGES; b < (s + 1) * SHIFT_WIDTH / STAGES; b++)
      if (y.sh[b]) begin
        m = ~(ONES << (1 << b)) & y.om;
        y.st = y.st | (|(y.d & m));
        y.sa = y.sa & (&(y.d | ~m));
        y.d = y.d >> (1 << b);
`ifdef SHIFT_RIGHT_STICKY_PIPE_ARITH_EN
        y.d = y.d | (y.f ? ~(ONES >> (1 << b)) : '0);
`endif
        y.om = y.om >> (1 << b);
      end
    return y;
  endfunction
  logic [STAGES-1:0] v_q, v_d, ld;
  stg_t p_q [STAGES];
  stg_t p_d [STAGES];
  stg_t s0;
`ifndef SHIFT_RIGHT_STICKY_PIPE_ARITH_EN
  logic unused_arith;
  assign unused_arith = arith;
`endif
  always_comb begin
`ifdef SHIFT_RIGHT_STICKY_PIPE_ARITH_EN
    s0 = '{d: in, om: ONES, sh: shift, st: 1'b0, sa: 1'b1, f: arith & in[IN_WIDTH-1]};
`else
    s0 = '{d: in, om: ONES, sh: shift, st: 1'b0, sa: 1'b1, f: 1'b0};
`endif
    // A stage loads when the consumer takes the result or any stage from it onward is empty.
    for (int s = 0; s < STAGES; s++) ld[s] = outReady | ~&(v_q | STAGES'((1 << s) - 1));
    v_d[0] = ld[0] ? inValid : v_q[0];
    p_d[0] = ld[0] && inValid ? step(s0, 0) : p_q[0];
    for (int s = 1; s < STAGES; s++) begin
      v_d[s] = ld[s] ? v_q[s-1] : v_q[s];
      p_d[s] = ld[s] && v_q[s-1] ? step(p_q[s-1], s) : p_q[s];
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      v_q <= '0;
      p_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      p_q <= p_d;
    end
  assign inReady   = ld[0];
  assign outValid  = v_q[STAGES-1];
  assign out       = OUT_WIDTH'({{OUT_WIDTH{p_q[STAGES-1].f}}, p_q[STAGES-1].d});
  assign sticky    = p_q[STAGES-1].st;
  assign stickyAnd = p_q[STAGES-1].sa;
endmodule

// File: tb/tb_shift_right_sticky_pipe.sv
// tb_shift_right_sticky_pipe: randomized and directed checks against a rule-level model.
module tb_shift_right_sticky_pipe;
`ifdef SHIFT_RIGHT_STICKY_PIPE_ARITH_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, inValid = 1'b0, outReady = 1'b0, ar = 1'b0;
  logic inReady, outValid, sticky, stickyAnd;
  logic [5:0] din = '0, out;
  logic [2:0] sh = '0;
  int total = 0, bad = 0;
  logic [7:0] q [$];
  always #5 clock = ~clock;
  shift_right_sticky_pipe dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady), .in(din),
    .shift(sh), .arith(ar), .outValid(outValid), .outReady(outReady), .out(out),
    .sticky(sticky), .stickyAnd(stickyAnd)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Bit i of the result is in[i+s] when that exists, else the fill bit; sticky bits
  // cover every input position below s.
  function automatic logic [7:0] model(input logic [5:0] a, input logic [2:0] s, input logic r);
    logic f, st, sa;
    logic [5:0] o;
    f = AR_EN & r & a[5];
    st = 1'b0;
    sa = 1'b1;
    for (int i = 0; i < 6; i++) o[i] = (i + int'(s) < 6) ? a[i+int'(s)] : f;
    for (int j = 0; j < 6; j++)
      if (j < int'(s)) begin
        st = st | a[j];
        sa = sa & a[j];
      end
    return {o, st, sa};
  endfunction
  task automatic dir(input string tag, input logic [5:0] a, input logic [2:0] s, input logic r,
                     input logic [7:0] e);
    @(posedge clock) #1;
    inValid = 1'b1; din = a; sh = s; ar = r; outReady = 1'b1;
    @(posedge clock) #1;
    inValid = 1'b0;
    @(negedge clock) chk({tag, "_lat0"}, outValid, 0);
    @(negedge clock) chk({tag, "_lat1"}, outValid, 1);
    chk({tag, "_res"}, {out, sticky, stickyAnd}, e);
  endtask
  initial begin
    logic [7:0] e, hold;
    logic acc, stall;
    int n, idx, rcv;
    #2 chk("rst_async_ov", outValid, 0);
    @(posedge clock) #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_out", {out, sticky, stickyAnd, outValid}, 0);
    chk("rst_rdy", inReady, 1);
    dir("r035", 6'b101101, 3'd2, 1'b0, {6'b001011, 1'b1, 1'b0});
    dir("r036", 6'b100000, 3'd7, 1'b1, model(6'b100000, 3'd7, 1'b1));
    dir("r036_log", 6'b100000, 3'd7, 1'b0, {6'b000000, 1'b1, 1'b0});
    dir("r037a", 6'b000000, 3'd0, 1'b0, {6'b000000, 1'b0, 1'b1});
    dir("r037b", 6'b000111, 3'd3, 1'b0, {6'b000000, 1'b1, 1'b1});
    dir("sat6", 6'b111111, 3'd6, 1'b0, {6'b000000, 1'b1, 1'b1});
    @(posedge clock) #1;
    outReady = 1'b0; inValid = 1'b1; din = $urandom; sh = $urandom; ar = $urandom;
    n = 0;
    repeat (5) begin
      @(negedge clock);
      acc = inReady;
      if (acc) begin
        q.push_back(model(din, sh, ar));
        n++;
      end
      @(posedge clock) #1;
      if (acc) begin
        din = $urandom; sh = $urandom; ar = $urandom;
      end
    end
    chk("stall_acc", n, 2);
    @(negedge clock) chk("stall_rdy", inReady, 0);
    @(posedge clock) #1;
    outReady = 1'b1; inValid = 1'b0;
    repeat (2) begin
      @(negedge clock);
      chk("stall_ov", outValid, 1);
      e = q.pop_front();
      chk("stall_order", {out, sticky, stickyAnd}, e);
    end
    @(negedge clock) chk("stall_empty", outValid, 0);
    @(posedge clock) #1;
    outReady = 1'b0; inValid = 1'b1; din = 6'h2a; sh = 3'd1;
    repeat (2) @(posedge clock);
    #1 inValid = 1'b0;
    @(negedge clock) chk("rst_pre", outValid, 1);
    @(posedge clock) #3 reset = 1'b1;
    #1 chk("rst_mid_ov", outValid, 0);
    @(posedge clock) #1;
    reset = 1'b0; outReady = 1'b1;
    @(negedge clock) chk("rst_clear", {out, sticky, stickyAnd}, 0);
    n = 0;
    repeat (4) @(negedge clock) n += int'(outValid);
    chk("rst_no_stale", n, 0);
    idx = 0; rcv = 0; stall = 1'b0; hold = '0;
    for (int c = 0; c < 20000 && rcv < 1024; c++) begin
      @(posedge clock) #1;
      inValid = idx < 1024 && $urandom_range(0, 7) != 0;
      {ar, sh, din} = 10'(idx);
      outReady = $urandom_range(0, 2) != 0;
      @(negedge clock);
      chk("rdy", inReady, q.size() < 2 || outReady);
      if (stall) chk("hold", {outValid, out, sticky, stickyAnd}, {1'b1, hold});
      if (outValid && outReady) begin
        if (q.size() == 0) chk("dup", 1, 0);
        else begin
          e = q.pop_front();
          chk("res", {out, sticky, stickyAnd}, e);
        end
        rcv++;
      end
      if (inValid && inReady) begin
        q.push_back(model(din, sh, ar));
        idx++;
      end
      stall = outValid && !outReady;
      hold = {out, sticky, stickyAnd};
    end
    chk("drained", rcv, 1024);
    chk("left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
